// File: rtl/core_seq_ctrl_if.sv
// Shared instruction/data memory port. The master raises req and holds it until gnt.
// Read data comes back later on rvalid.
interface core_seq_ctrl_if #(
    parameter int unsigned PC_W = 16
);
    logic            req;
    logic            we;
    logic [PC_W-1:0] addr;
    logic [31:0]     wdata;
    logic            gnt;
    logic            rvalid;
    logic [31:0]     rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/core_seq_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer. It owns the PC and shares one memory port
// between instruction fetch and LOAD/STORE accesses. It also steers the register file and ALU.
module core_seq_ctrl #(
    parameter int unsigned     PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_i,
    output logic              busy_o,
    output logic [PC_W-1:0]   pc_o,
    output logic              retire_o,
    output logic              illegal_o,
    core_seq_ctrl_if.master   mem,
    output logic [2:0]        rf_raddr1_o,
    output logic [2:0]        rf_raddr2_o,
    input  logic [31:0]       rf_rdata1_i,
    input  logic [31:0]       rf_rdata2_i,
    output logic              rf_we_o,
    output logic [2:0]        rf_waddr_o,
    output logic [31:0]       rf_wdata_o,
    output logic [2:0]        alu_op_o,
    output logic [31:0]       alu_a_o,
    output logic [31:0]       alu_b_o,
    input  logic [31:0]       alu_y_i
);
    localparam logic [5:0] OpNop   = 6'd0;
    localparam logic [5:0] OpAdd   = 6'd1;
    localparam logic [5:0] OpSub   = 6'd2;
    localparam logic [5:0] OpAddi  = 6'd3;
    localparam logic [5:0] OpLoad  = 6'd4;
    localparam logic [5:0] OpStore = 6'd5;

    typedef enum logic [2:0] {
        AluNop = 3'd0,
        AluAdd = 3'd1,
        AluSub = 3'd2
    } alu_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StFwait,
        StExec,
        StMem,
        StMwait,
        StTrap
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic            illegal_q, illegal_d;

    logic [5:0]      opcode;
    logic [2:0]      rd;
    logic [31:0]     imm_ext;
    logic            is_alu;
    logic            is_mem;
    logic            is_store;
    alu_op_e         alu_op;

    logic            retire;
    logic            mem_req;
    logic            mem_we;
    logic [PC_W-1:0] mem_addr;

    assign opcode   = ir_q[31:26];
    assign rd       = ir_q[25:23];
    assign imm_ext  = {{16{ir_q[19]}}, ir_q[19:4]};
    assign is_store = (opcode == OpStore);

    // STORE reuses the rd field as its data source register
    assign rf_raddr1_o = ir_q[22:20];
    assign rf_raddr2_o = is_store ? rd : ir_q[19:17];
    assign alu_a_o     = rf_rdata1_i;
    assign alu_op_o    = alu_op;

    always_comb begin
        alu_op  = AluNop;
        alu_b_o = '0;
        is_alu  = 1'b0;
        is_mem  = 1'b0;
        case (opcode)
            OpAdd: begin
                alu_op  = AluAdd;
                alu_b_o = rf_rdata2_i;
                is_alu  = 1'b1;
            end
            OpSub: begin
                alu_op  = AluSub;
                alu_b_o = rf_rdata2_i;
                is_alu  = 1'b1;
            end
            OpAddi: begin
                alu_op  = AluAdd;
                alu_b_o = imm_ext;
                is_alu  = 1'b1;
            end
            OpLoad, OpStore: begin
                alu_op  = AluAdd;
                alu_b_o = imm_ext;
                is_mem  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        illegal_d  = illegal_q;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        rf_we_o    = 1'b0;
        rf_waddr_o = '0;
        rf_wdata_o = '0;
        case (state_q)
            StIdle: begin
                if (run_i) state_d = StFetch;
            end
            StFetch: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
                if (mem.gnt) state_d = StFwait;
            end
            StFwait: begin
                if (mem.rvalid) begin
                    ir_d    = mem.rdata;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (is_alu) begin
                    rf_we_o    = 1'b1;
                    rf_waddr_o = rd;
                    rf_wdata_o = alu_y_i;
                    retire     = 1'b1;
                end else if (is_mem) begin
                    state_d = StMem;
                end else if (opcode == OpNop) begin
                    retire = 1'b1;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = StTrap;
                end
            end
            StMem: begin
                mem_req  = 1'b1;
                mem_we   = is_store;
                mem_addr = alu_y_i[PC_W-1:0];
                if (mem.gnt) begin
                    if (is_store) retire = 1'b1;
                    else          state_d = StMwait;
                end
            end
            StMwait: begin
                if (mem.rvalid) begin
                    rf_we_o    = 1'b1;
                    rf_waddr_o = rd;
                    rf_wdata_o = mem.rdata;
                    retire     = 1'b1;
                end
            end
            StTrap: ;
            default: state_d = StIdle;
        endcase
        if (retire) begin
            pc_d    = pc_q + PC_W'(1);
            state_d = run_i ? StFetch : StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    assign mem.req   = mem_req;
    assign mem.we    = mem_we;
    assign mem.addr  = mem_addr;
    assign mem.wdata = mem_we ? rf_rdata2_i : '0;

    assign busy_o    = (state_q != StIdle) && (state_q != StTrap);
    assign pc_o      = pc_q;
    assign retire_o  = retire;
    assign illegal_o = illegal_q;

    logic unused_bits;
    assign unused_bits = ^{ir_q[3:0], alu_y_i};
endmodule
